// File: rtl/vpu_pkg.sv
// ============================================================================
// Module  : vpu_pkg
// Brief   : Shared opcode and sequencer-state definitions for the vector unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vpu_pkg;

   localparam int VPU_OP_W = 4;

   typedef enum logic [VPU_OP_W-1:0] {
      VPU_ADD  = 4'd0,
      VPU_SUB  = 4'd1,
      VPU_RELU = 4'd2
   } vpu_opcode_e;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2,
      SEQ_FIN   = 2'd3
   } vpu_seq_state_e;

endpackage : vpu_pkg

`default_nettype wire

// File: rtl/vpu_vec_seq.sv
// ============================================================================
// Module  : vpu_vec_seq
// Brief   : Vector command sequencer feeding the combinational VPU ALU with a
//           single registered result stage on a valid/ready output stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vpu_vec_seq
   import vpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_opcode,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_op0,
   input  logic [DATA_W-1:0] in_op1,
   output logic              op_start,
   output logic [DATA_W-1:0] op_operand0,
   output logic [DATA_W-1:0] op_operand1,
   output logic [OP_W-1:0]   op_opcode,
   input  logic [DATA_W-1:0] op_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   vpu_seq_state_e    r_state;
   vpu_seq_state_e    w_state_nxt;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_len;
   logic [OP_W-1:0]   r_opcode;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic              w_accept;
   logic              w_is_last;
   logic              w_out_hs;

   assign w_is_last = (r_cnt == (r_len - LEN_W'(1)));
   assign w_out_hs  = r_out_valid && out_ready;

   assign op_opcode = r_opcode;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign busy      = (r_state != SEQ_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      in_ready    = 1'b0;
      op_start    = 1'b0;
      op_operand0 = '0;
      op_operand1 = '0;
      done        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = (cmd_len == '0) ? SEQ_FIN : SEQ_RUN;
            end
         end
         SEQ_RUN: begin
            // A pending result may be replaced in the same cycle it is consumed.
            in_ready    = !r_out_valid || out_ready;
            w_accept    = in_valid && in_ready;
            op_start    = w_accept;
            op_operand0 = in_op0;
            op_operand1 = in_op1;
            if (w_accept && w_is_last) begin
               w_state_nxt = SEQ_DRAIN;
            end
         end
         SEQ_DRAIN: begin
            if (w_out_hs) begin
               w_state_nxt = SEQ_FIN;
            end
         end
         SEQ_FIN: begin
            done        = 1'b1;
            w_state_nxt = SEQ_IDLE;
         end
         default: w_state_nxt = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SEQ_IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_opcode    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            SEQ_IDLE: begin
               if (cmd_valid) begin
                  r_opcode <= cmd_opcode;
                  r_len    <= cmd_len;
                  r_cnt    <= '0;
               end
            end
            SEQ_RUN: begin
               if (w_accept) begin
                  r_out_data  <= op_result;
                  r_out_valid <= 1'b1;
                  r_out_last  <= w_is_last;
                  r_cnt       <= r_cnt + LEN_W'(1);
               end else if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
            end
            SEQ_DRAIN: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : vpu_vec_seq

`default_nettype wire

// File: tb/tb_vpu_vec_seq.sv
// ============================================================================
// Module  : tb_vpu_vec_seq
// Brief   : Directed self-checking bench for vpu_vec_seq with a table-driven
//           stand-in for the vpu_op ALU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vpu_vec_seq;
   import vpu_pkg::*;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_opcode = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_op0 = '0;
   logic [DATA_W-1:0] in_op1 = '0;
   logic              op_start;
   logic [DATA_W-1:0] op_operand0;
   logic [DATA_W-1:0] op_operand1;
   logic [OP_W-1:0]   op_opcode;
   logic [DATA_W-1:0] op_result;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   vpu_vec_seq #(.DATA_W(DATA_W), .OP_W(OP_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_len    (cmd_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op0     (in_op0),
      .in_op1     (in_op1),
      .op_start   (op_start),
      .op_operand0(op_operand0),
      .op_operand1(op_operand1),
      .op_opcode  (op_opcode),
      .op_result  (op_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   // Stand-in ALU: exact FP32 results for the operand pairs used below.
   function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h3F800000_40000000: f_add = 32'h40400000;
         64'h3F800000_3F800000: f_add = 32'h40000000;
         64'h40000000_40000000: f_add = 32'h40800000;
         64'h40400000_40400000: f_add = 32'h40C00000;
         default:               f_add = 32'hDEADBEEF;
      endcase
   endfunction

   function automatic logic [31:0] f_sub(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         64'h40400000_3F800000: f_sub = 32'h40000000;
         64'h40000000_40000000: f_sub = 32'h00000000;
         64'h3F800000_40400000: f_sub = 32'hC0000000;
         default:               f_sub = 32'hDEADBEEF;
      endcase
   endfunction

   always_comb begin
      op_result = '0;
      case (op_opcode)
         VPU_ADD:  op_result = f_add(op_operand0, op_operand1);
         VPU_SUB:  op_result = f_sub(op_operand0, op_operand1);
         VPU_RELU: op_result = op_operand0[31] ? 32'h0 : op_operand0;
         default:  op_result = '0;
      endcase
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [OP_W-1:0] op, input logic [LEN_W-1:0] len);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_len    = len;
      #1;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_op0   = a;
      in_op1   = b;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] sub_a [3];
      logic [31:0] sub_b [3];
      logic [31:0] sub_r [3];
      int hs_base;
      sub_a = '{32'h40400000, 32'h40000000, 32'h3F800000};
      sub_b = '{32'h3F800000, 32'h40000000, 32'h40400000};
      sub_r = '{32'h40000000, 32'h00000000, 32'hC0000000};

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // ADD, len=1
      send_cmd(VPU_ADD, 16'd1);
      chk("add1_busy", 32'(busy), 32'd1);
      chk("add1_cmd_ready_run", 32'(cmd_ready), 32'd0);
      out_ready = 1'b1;
      drive_pair(32'h3F800000, 32'h40000000);
      chk("add1_in_ready", 32'(in_ready), 32'd1);
      chk("add1_op_start", 32'(op_start), 32'd1);
      chk("add1_op_opcode", 32'(op_opcode), 32'(VPU_ADD));
      chk("add1_out_valid_pre", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("add1_out_valid", 32'(out_valid), 32'd1);
      chk("add1_out_data", out_data, 32'h40400000);
      chk("add1_out_last", 32'(out_last), 32'd1);
      chk("add1_in_ready_drain", 32'(in_ready), 32'd0);
      chk("add1_done_early", 32'(done), 32'd0);
      tick();
      chk("add1_done", 32'(done), 32'd1);
      chk("add1_fin_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("add1_fin_out_valid", 32'(out_valid), 32'd0);
      tick();
      chk("add1_done_clear", 32'(done), 32'd0);
      chk("add1_idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // SUB, len=3, out_ready held high
      send_cmd(VPU_SUB, 16'd3);
      for (int i = 0; i < 3; i++) begin
         drive_pair(sub_a[i], sub_b[i]);
         chk("sub_op_start", 32'(op_start), 32'd1);
         tick();
         chk("sub_out_valid", 32'(out_valid), 32'd1);
         chk("sub_out_data", out_data, sub_r[i]);
         chk("sub_out_last", 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      tick();
      chk("sub_done", 32'(done), 32'd1);
      tick();

      // RELU, len=2, with an idle input cycle between elements
      send_cmd(VPU_RELU, 16'd2);
      drive_pair(32'hBF800000, 32'h0);
      chk("relu_op_start0", 32'(op_start), 32'd1);
      tick();
      chk("relu_out_data0", out_data, 32'h00000000);
      chk("relu_out_last0", 32'(out_last), 32'd0);
      in_valid = 1'b0;
      #1;
      chk("relu_op_start_idle", 32'(op_start), 32'd0);
      tick();
      chk("relu_out_valid_idle", 32'(out_valid), 32'd0);
      drive_pair(32'h3F800000, 32'h0);
      chk("relu_op_start1", 32'(op_start), 32'd1);
      chk("relu_op_opcode", 32'(op_opcode), 32'(VPU_RELU));
      tick();
      in_valid = 1'b0;
      #1;
      chk("relu_out_data1", out_data, 32'h3F800000);
      chk("relu_out_last1", 32'(out_last), 32'd1);
      chk("relu_op_start_drain", 32'(op_start), 32'd0);
      tick();
      chk("relu_done", 32'(done), 32'd1);
      tick();

      // Backpressure: ADD len=4, out_ready low for 3 cycles after first result
      hs_base = hs_cnt;
      send_cmd(VPU_ADD, 16'd4);
      drive_pair(32'h3F800000, 32'h3F800000);
      tick();
      chk("bp_out_data0", out_data, 32'h40000000);
      out_ready = 1'b0;
      drive_pair(32'h3F800000, 32'h40000000);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
         chk("bp_op_start_stall", 32'(op_start), 32'd0);
         tick();
         chk("bp_out_data_hold", out_data, 32'h40000000);
         chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
         chk("bp_out_last_hold", 32'(out_last), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_release", 32'(in_ready), 32'd1);
      tick();
      chk("bp_out_data1", out_data, 32'h40400000);
      drive_pair(32'h40000000, 32'h40000000);
      tick();
      chk("bp_out_data2", out_data, 32'h40800000);
      drive_pair(32'h40400000, 32'h40400000);
      tick();
      in_valid = 1'b0;
      #1;
      chk("bp_out_data3", out_data, 32'h40C00000);
      chk("bp_out_last3", 32'(out_last), 32'd1);
      tick();
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_hs_count", 32'(hs_cnt - hs_base), 32'd4);
      tick();

      // len=0 command
      send_cmd(VPU_ADD, 16'd0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_out_valid", 32'(out_valid), 32'd0);
      chk("len0_cmd_ready_fin", 32'(cmd_ready), 32'd0);
      tick();
      chk("len0_done_clear", 32'(done), 32'd0);
      chk("len0_cmd_ready", 32'(cmd_ready), 32'd1);

      // Reset in RUN after 2 of 5 elements
      send_cmd(VPU_ADD, 16'd5);
      drive_pair(32'h3F800000, 32'h3F800000);
      tick();
      drive_pair(32'h3F800000, 32'h40000000);
      tick();
      chk("rr_out_valid_pre", 32'(out_valid), 32'd1);
      chk("rr_out_data_pre", out_data, 32'h40400000);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rr_out_valid", 32'(out_valid), 32'd0);
      chk("rr_out_data", out_data, 32'd0);
      chk("rr_out_last", 32'(out_last), 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      chk("rr_done", 32'(done), 32'd0);
      chk("rr_op_opcode", 32'(op_opcode), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rr_no_done", 32'(done), 32'd0);
      send_cmd(VPU_ADD, 16'd1);
      drive_pair(32'h3F800000, 32'h40000000);
      chk("rr_add_op_start", 32'(op_start), 32'd1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("rr_add_out_data", out_data, 32'h40400000);
      chk("rr_add_out_last", 32'(out_last), 32'd1);
      tick();
      chk("rr_add_done", 32'(done), 32'd1);
      tick();
      chk("rr_add_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_vpu_vec_seq

`default_nettype wire
